lsu_mem_tag_tracker: RTL and testbench
======================================

Name: lsu_mem_tag_tracker

Overview:
- Parametrised outstanding-request tracker between the LSU issue logic and the memory interface.
- Allocates a memory tag per issued request and records its wavefront ID, destination register, PC and load/store kind.
- Matches returning mem_ack/mem2lsu_tag responses to those records and retires completed requests in order, one per cycle, toward the done/tracemon path.
- Replaces the fixed single-tag-space scheme: depth, tag width and field widths are generic, out-of-order acknowledges are supported, retire has backpressure, and bad tags are reported.

Parameters:
DEPTH, 16, number of tracker entries; power of two, 2..128
TAG_W, 4, tag width; equals log2(DEPTH)
WFID_W, 6, wavefront ID width
DEST_W, 12, destination register field width
PC_W, 32, instruction PC width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
alloc_valid  in  1  LSU requests a new tag this cycle
alloc_ready  out  1  at least one entry is FREE
alloc_tag  out  TAG_W  tag granted when alloc_valid && alloc_ready
alloc_wfid  in  WFID_W  wavefront of the request
alloc_dest_reg  in  DEST_W  destination register of the request
alloc_pc  in  PC_W  instruction PC
alloc_is_store  in  1  1 = store, 0 = load
mem_ack  in  1  memory response valid
mem2lsu_tag  in  TAG_W  tag of the memory response
retire_valid  out  1  a completed entry is presented
retire_ready  in  1  downstream accepts the retire
retire_tag  out  TAG_W  tag of the presented entry
retire_wfid  out  WFID_W  wavefront ID of the presented entry
retire_dest_reg  out  DEST_W  destination register of the presented entry
retire_pc  out  PC_W  PC of the presented entry
retire_is_store  out  1  store/load kind of the presented entry
occupancy  out  TAG_W+1  count of non-FREE entries
err_bad_ack  out  1  one-cycle pulse, registered: ack to an entry not PENDING

Behaviour:
- Per-entry state machine: FREE -> PENDING (alloc handshake) -> DONE (mem_ack with a matching tag) -> FREE (retire handshake). No other transitions.
- Reset (rst=0, asynchronous):
  - all entries FREE; occupancy=0; err_bad_ack=0.
  - retire_valid=0; all retire_* fields read 0.
  - Asserting reset mid-operation discards every PENDING/DONE entry; no retire is produced for them.
  - Acknowledges arriving after reset release for old tags count as bad acks.
- Allocation:
  - alloc_ready = OR of FREE flags, taken from registered state.
  - alloc_tag = lowest-index FREE entry, combinational from registered state.
  - On an alloc handshake, the entry captures wfid/dest/pc/is_store and becomes PENDING at the next edge.
  - alloc_valid while alloc_ready=0 is ignored; the requester holds the request.
- Acknowledge:
  - mem_ack=1 with mem2lsu_tag pointing at a PENDING entry moves it to DONE at the next edge.
  - Tag pointing at a FREE or DONE entry: no state change, err_bad_ack=1 for the following cycle.
- Retire:
  - retire_valid = any DONE entry.
  - The presented entry is the lowest-index DONE entry; fields are combinational from its stored record.
  - Presented fields stay stable while retire_valid && !retire_ready, unless a lower-index entry becomes DONE; the presented entry is then allowed to change.
  - On the handshake, the entry becomes FREE at the next edge.
- Latency: ack at edge N gives retire_valid=1 after edge N; minimum alloc-to-retire is 2 cycles.
- Simultaneous events:
  - alloc, ack and retire on distinct entries in one cycle all take effect.
  - An entry freed by retire is not allocatable until the following cycle.
  - An ack to an entry allocated in the same cycle is a bad ack, because the entry is still FREE.
- occupancy: +1 on alloc handshake, -1 on retire handshake, net 0 when both occur; never exceeds DEPTH.
- Full: occupancy=DEPTH gives alloc_ready=0. Empty: retire_valid=0.
- Tag index arithmetic has no wrap-around; tags are entry indices, not sequence numbers.

Test Plan:
- Reset, then allocate wfid=2, pc=60, dest=0xC10, load -> alloc_tag=0; occupancy=1; ack tag 0 -> next cycle retire_valid=1, retire_wfid=2, retire_pc=60, retire_dest_reg=0xC10.
- Allocate 3 entries (tags 0,1,2); ack tags 2 then 0, retire_ready=1 -> retires tag 0 first, then tag 2; occupancy returns to 1.
- Fill DEPTH=16 entries -> alloc_ready=0 on the 16th handshake's next cycle; the 17th alloc_valid is ignored; retire tag 5 -> the next alloc_tag is 5, one cycle after the retire.
- Ack tag 7 while FREE, then ack an already DONE tag -> err_bad_ack pulses one cycle each; state and occupancy are unchanged.
- Hold retire_ready=0 with tag 3 DONE for 4 cycles -> retire fields stay stable; then alloc+ack+retire in the same cycle -> occupancy unchanged, all three take effect.
- With 5 entries busy, drop rst mid-cycle -> immediate occupancy=0, retire_valid=0; after release, the first alloc_tag=0.

Source files
------------

// File: rtl/lsu_mem_tag_tracker.sv
// Outstanding memory request tracker: allocates a tag per issued LSU
// request, records its metadata, marks it complete on a matching ack and
// retires completed entries lowest-index first, one per cycle.
module lsu_mem_tag_tracker #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned WFID_W = 6,
  parameter int unsigned DEST_W = 12,
  parameter int unsigned PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic [WFID_W-1:0] alloc_wfid,
  input  logic [DEST_W-1:0] alloc_dest_reg,
  input  logic [PC_W-1:0]   alloc_pc,
  input  logic              alloc_is_store,
  input  logic              mem_ack,
  input  logic [TAG_W-1:0]  mem2lsu_tag,
  output logic              retire_valid,
  input  logic              retire_ready,
  output logic [TAG_W-1:0]  retire_tag,
  output logic [WFID_W-1:0] retire_wfid,
  output logic [DEST_W-1:0] retire_dest_reg,
  output logic [PC_W-1:0]   retire_pc,
  output logic              retire_is_store,
  output logic [TAG_W:0]    occupancy,
  output logic              err_bad_ack
);

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_DONE    = 2'd2
  } ent_state_e;

  typedef struct packed {
    logic [WFID_W-1:0] wfid;
    logic [DEST_W-1:0] dest;
    logic [PC_W-1:0]   pc;
    logic              is_store;
  } rec_t;

  ent_state_e r_state     [DEPTH];
  ent_state_e w_state_nxt [DEPTH];
  rec_t       r_rec       [DEPTH];

  logic [TAG_W:0]   r_occ;
  logic             r_err_bad_ack;

  logic             w_any_free;
  logic [TAG_W-1:0] w_free_idx;
  logic             w_any_done;
  logic [TAG_W-1:0] w_done_idx;
  logic             w_alloc_fire;
  logic             w_retire_fire;
  logic             w_bad_ack;
  rec_t             w_ret_rec;

  // Lowest-index FREE and DONE entries (scan high to low so the lowest wins)
  always_comb begin
    w_any_free = 1'b0;
    w_free_idx = '0;
    w_any_done = 1'b0;
    w_done_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (r_state[i] == ST_FREE) begin
        w_any_free = 1'b1;
        w_free_idx = TAG_W'(i);
      end
      if (r_state[i] == ST_DONE) begin
        w_any_done = 1'b1;
        w_done_idx = TAG_W'(i);
      end
    end
  end

  assign w_alloc_fire  = alloc_valid && w_any_free;
  assign w_retire_fire = w_any_done && retire_ready;

  // Per-entry next state; alloc, ack and retire always target distinct entries
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_state_nxt[i] = r_state[i];
    end
    w_bad_ack = 1'b0;
    if (w_alloc_fire) begin
      w_state_nxt[w_free_idx] = ST_PENDING;
    end
    if (mem_ack) begin
      if (r_state[mem2lsu_tag] == ST_PENDING) begin
        w_state_nxt[mem2lsu_tag] = ST_DONE;
      end else begin
        w_bad_ack = 1'b1;
      end
    end
    if (w_retire_fire) begin
      w_state_nxt[w_done_idx] = ST_FREE;
    end
  end

  // Entry state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_state[i] <= ST_FREE;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_state[i] <= w_state_nxt[i];
      end
    end
  end

  // Request record capture on the alloc handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_rec[i] <= '0;
      end
    end else if (w_alloc_fire) begin
      r_rec[w_free_idx] <= '{wfid: alloc_wfid, dest: alloc_dest_reg,
                             pc: alloc_pc, is_store: alloc_is_store};
    end
  end

  // Occupancy counter and registered bad-ack pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ         <= '0;
      r_err_bad_ack <= 1'b0;
    end else begin
      r_err_bad_ack <= w_bad_ack;
      case ({w_alloc_fire, w_retire_fire})
        2'b10:   r_occ <= r_occ + (TAG_W+1)'(1);
        2'b01:   r_occ <= r_occ - (TAG_W+1)'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Presented retire record reads zero when nothing is DONE
  assign w_ret_rec = w_any_done ? r_rec[w_done_idx] : '0;

  assign alloc_ready     = w_any_free;
  assign alloc_tag       = w_free_idx;
  assign retire_valid    = w_any_done;
  assign retire_tag      = w_done_idx;
  assign retire_wfid     = w_ret_rec.wfid;
  assign retire_dest_reg = w_ret_rec.dest;
  assign retire_pc       = w_ret_rec.pc;
  assign retire_is_store = w_ret_rec.is_store;
  assign occupancy       = r_occ;
  assign err_bad_ack     = r_err_bad_ack;

endmodule

// File: tb/tb_lsu_mem_tag_tracker.sv
// Directed self-checking bench for lsu_mem_tag_tracker (DEPTH=16).
module tb_lsu_mem_tag_tracker;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned WFID_W = 6;
  localparam int unsigned DEST_W = 12;
  localparam int unsigned PC_W   = 32;

  logic              clk;
  logic              rst;
  logic              alloc_valid;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic [WFID_W-1:0] alloc_wfid;
  logic [DEST_W-1:0] alloc_dest_reg;
  logic [PC_W-1:0]   alloc_pc;
  logic              alloc_is_store;
  logic              mem_ack;
  logic [TAG_W-1:0]  mem2lsu_tag;
  logic              retire_valid;
  logic              retire_ready;
  logic [TAG_W-1:0]  retire_tag;
  logic [WFID_W-1:0] retire_wfid;
  logic [DEST_W-1:0] retire_dest_reg;
  logic [PC_W-1:0]   retire_pc;
  logic              retire_is_store;
  logic [TAG_W:0]    occupancy;
  logic              err_bad_ack;

  int n_checks;
  int n_errors;

  lsu_mem_tag_tracker #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .WFID_W(WFID_W), .DEST_W(DEST_W), .PC_W(PC_W)
  ) u_dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_wfid(alloc_wfid), .alloc_dest_reg(alloc_dest_reg), .alloc_pc(alloc_pc),
    .alloc_is_store(alloc_is_store),
    .mem_ack(mem_ack), .mem2lsu_tag(mem2lsu_tag),
    .retire_valid(retire_valid), .retire_ready(retire_ready), .retire_tag(retire_tag),
    .retire_wfid(retire_wfid), .retire_dest_reg(retire_dest_reg), .retire_pc(retire_pc),
    .retire_is_store(retire_is_store),
    .occupancy(occupancy), .err_bad_ack(err_bad_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alloc(input logic v, input int wfid, input int dest, input int pc,
                           input logic st);
    alloc_valid    = v;
    alloc_wfid     = WFID_W'(wfid);
    alloc_dest_reg = DEST_W'(dest);
    alloc_pc       = PC_W'(pc);
    alloc_is_store = st;
  endtask

  task automatic do_reset();
    alloc_valid  = 1'b0;
    mem_ack      = 1'b0;
    retire_ready = 1'b0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    set_alloc(1'b0, 0, 0, 0, 1'b0);
    mem_ack      = 1'b0;
    mem2lsu_tag  = '0;
    retire_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_occ",      64'(occupancy), 64'd0);
    chk("rst_rvalid",   64'(retire_valid), 64'd0);
    chk("rst_err",      64'(err_bad_ack), 64'd0);
    chk("rst_aready",   64'(alloc_ready), 64'd1);
    chk("rst_atag",     64'(alloc_tag), 64'd0);
    chk("rst_rwfid",    64'(retire_wfid), 64'd0);
    chk("rst_rpc",      64'(retire_pc), 64'd0);
    chk("rst_rdest",    64'(retire_dest_reg), 64'd0);
    rst = 1'b1;
    step();

    // Single load: alloc, ack, retire
    set_alloc(1'b1, 2, 'hC10, 60, 1'b0);
    #1;
    chk("t1_atag", 64'(alloc_tag), 64'd0);
    step();
    alloc_valid = 1'b0;
    chk("t1_occ",    64'(occupancy), 64'd1);
    chk("t1_rv_pre", 64'(retire_valid), 64'd0);
    mem_ack = 1'b1; mem2lsu_tag = 4'd0;
    step();
    mem_ack = 1'b0;
    chk("t1_rvalid", 64'(retire_valid), 64'd1);
    chk("t1_rtag",   64'(retire_tag), 64'd0);
    chk("t1_rwfid",  64'(retire_wfid), 64'd2);
    chk("t1_rpc",    64'(retire_pc), 64'd60);
    chk("t1_rdest",  64'(retire_dest_reg), 64'hC10);
    chk("t1_rst",    64'(retire_is_store), 64'd0);
    retire_ready = 1'b1;
    step();
    retire_ready = 1'b0;
    chk("t1_occ0",   64'(occupancy), 64'd0);
    chk("t1_rv0",    64'(retire_valid), 64'd0);

    // Out-of-order acks retire lowest index first
    for (int i = 0; i < 3; i++) begin
      set_alloc(1'b1, 10 + i, 1 + i, 100 + 4 * i, 1'b0);
      #1;
      chk("t2_atag", 64'(alloc_tag), 64'(i));
      step();
    end
    alloc_valid = 1'b0;
    mem_ack = 1'b1; mem2lsu_tag = 4'd2;
    step();
    chk("t2_first_done", 64'(retire_tag), 64'd2);
    mem2lsu_tag = 4'd0;
    step();
    mem_ack = 1'b0;
    retire_ready = 1'b1;
    #1;
    chk("t2_r0_tag",  64'(retire_tag), 64'd0);
    chk("t2_r0_wfid", 64'(retire_wfid), 64'd10);
    step();
    chk("t2_r2_tag",  64'(retire_tag), 64'd2);
    chk("t2_r2_wfid", 64'(retire_wfid), 64'd12);
    chk("t2_r2_pc",   64'(retire_pc), 64'd108);
    step();
    retire_ready = 1'b0;
    chk("t2_occ",     64'(occupancy), 64'd1);
    chk("t2_rv",      64'(retire_valid), 64'd0);

    // Fill all entries, full behaviour, reuse of a retired tag
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_alloc(1'b1, i, i, 1000 + 4 * i, (i % 2) == 1);
      #1;
      chk("t3_atag", 64'(alloc_tag), 64'(i));
      step();
    end
    set_alloc(1'b1, 63, 'h3FF, 'h5555, 1'b0);
    chk("t3_full_ready", 64'(alloc_ready), 64'd0);
    chk("t3_full_occ",   64'(occupancy), 64'd16);
    step();
    chk("t3_ign_occ",    64'(occupancy), 64'd16);
    mem_ack = 1'b1; mem2lsu_tag = 4'd5;
    step();
    mem_ack = 1'b0;
    chk("t3_r_tag",   64'(retire_tag), 64'd5);
    chk("t3_r_wfid",  64'(retire_wfid), 64'd5);
    chk("t3_r_pc",    64'(retire_pc), 64'd1020);
    chk("t3_r_store", 64'(retire_is_store), 64'd1);
    retire_ready = 1'b1;
    #1;
    chk("t3_ret_cycle_ready", 64'(alloc_ready), 64'd0);
    step();
    retire_ready = 1'b0;
    chk("t3_post_ready", 64'(alloc_ready), 64'd1);
    chk("t3_post_atag",  64'(alloc_tag), 64'd5);
    chk("t3_post_occ",   64'(occupancy), 64'd15);
    step();
    alloc_valid = 1'b0;
    chk("t3_refill_occ",   64'(occupancy), 64'd16);
    chk("t3_refill_ready", 64'(alloc_ready), 64'd0);

    // Bad acks: FREE tag, DONE tag, same-cycle allocated tag
    do_reset();
    mem_ack = 1'b1; mem2lsu_tag = 4'd7;
    step();
    mem_ack = 1'b0;
    chk("t4_free_err", 64'(err_bad_ack), 64'd1);
    chk("t4_free_occ", 64'(occupancy), 64'd0);
    chk("t4_free_rv",  64'(retire_valid), 64'd0);
    step();
    chk("t4_err_clr",  64'(err_bad_ack), 64'd0);
    set_alloc(1'b1, 9, 'h123, 400, 1'b1);
    step();
    alloc_valid = 1'b0;
    mem_ack = 1'b1; mem2lsu_tag = 4'd0;
    step();
    chk("t4_good_err", 64'(err_bad_ack), 64'd0);
    step();
    mem_ack = 1'b0;
    chk("t4_done_err", 64'(err_bad_ack), 64'd1);
    chk("t4_done_rv",  64'(retire_valid), 64'd1);
    chk("t4_done_tag", 64'(retire_tag), 64'd0);
    chk("t4_done_occ", 64'(occupancy), 64'd1);
    step();
    chk("t4_err_clr2", 64'(err_bad_ack), 64'd0);
    set_alloc(1'b1, 8, 'h222, 500, 1'b0);
    mem_ack = 1'b1; mem2lsu_tag = 4'd1;
    step();
    alloc_valid = 1'b0;
    mem_ack = 1'b0;
    chk("t4_same_err", 64'(err_bad_ack), 64'd1);
    chk("t4_same_occ", 64'(occupancy), 64'd2);
    chk("t4_same_tag", 64'(retire_tag), 64'd0);

    // Backpressure hold, then simultaneous alloc+ack+retire
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_alloc(1'b1, 20 + i, 'h100 + i, 2000 + 4 * i, 1'b0);
      step();
    end
    alloc_valid = 1'b0;
    mem_ack = 1'b1; mem2lsu_tag = 4'd3;
    step();
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_hold_tag",  64'(retire_tag), 64'd3);
      chk("t5_hold_wfid", 64'(retire_wfid), 64'd23);
      chk("t5_hold_pc",   64'(retire_pc), 64'd2012);
      step();
    end
    set_alloc(1'b1, 30, 'h200, 3000, 1'b1);
    mem_ack = 1'b1; mem2lsu_tag = 4'd1;
    retire_ready = 1'b1;
    #1;
    chk("t5_sim_atag", 64'(alloc_tag), 64'd4);
    step();
    alloc_valid = 1'b0; mem_ack = 1'b0; retire_ready = 1'b0;
    chk("t5_sim_occ",  64'(occupancy), 64'd4);
    chk("t5_sim_rtag", 64'(retire_tag), 64'd1);
    chk("t5_sim_rwf",  64'(retire_wfid), 64'd21);
    chk("t5_sim_atag2", 64'(alloc_tag), 64'd3);
    chk("t5_sim_err",  64'(err_bad_ack), 64'd0);

    // Mid-cycle reset discards outstanding work
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_alloc(1'b1, 40 + i, i, 4000 + 4 * i, 1'b0);
      step();
    end
    alloc_valid = 1'b0;
    mem_ack = 1'b1; mem2lsu_tag = 4'd2;
    step();
    mem_ack = 1'b0;
    chk("t6_pre_occ", 64'(occupancy), 64'd5);
    #3;
    rst = 1'b0;
    #1;
    chk("t6_rst_occ",  64'(occupancy), 64'd0);
    chk("t6_rst_rv",   64'(retire_valid), 64'd0);
    chk("t6_rst_rpc",  64'(retire_pc), 64'd0);
    #2;
    rst = 1'b1;
    step();
    chk("t6_atag",   64'(alloc_tag), 64'd0);
    chk("t6_aready", 64'(alloc_ready), 64'd1);
    mem_ack = 1'b1; mem2lsu_tag = 4'd2;
    step();
    mem_ack = 1'b0;
    chk("t6_old_err", 64'(err_bad_ack), 64'd1);
    chk("t6_old_occ", 64'(occupancy), 64'd0);
    chk("t6_old_rv",  64'(retire_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
